// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants for the transmit and future receive paths.
//   tx_state_t       - transmit frame states
//   UART_OVERSAMPLE  - baud ticks per bit period
//   UART_DATA_BITS   - data bits per frame
package uart_pkg;
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: host-side bundle of the transmit serializer.
//   i_brg   - baud divisor, tick period is i_brg+1 clocks
//   i_data  - byte to transmit
//   i_start - single-cycle start request
//   o_tx    - serial line, idle high
//   o_busy  - frame in progress
//   o_done  - one-cycle completion pulse
interface uart_tx_serializer_if;
    import uart_pkg::*;
    logic [7:0]                i_brg;
    logic [UART_DATA_BITS-1:0] i_data;
    logic                      i_start;
    logic                      o_tx;
    logic                      o_busy;
    logic                      o_done;
    modport master (output i_brg, i_data, i_start, input o_tx, o_busy, o_done);
    modport slave  (input i_brg, i_data, i_start, output o_tx, o_busy, o_done);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: divisor counter producing one oversample tick every div+1 clocks.
//   i_Clock - rising-edge clock
//   i_reset - asynchronous active-low reset
//   en      - count enable
//   clr     - restart the count from zero
//   div     - divisor, counter runs 0..div
//   tick    - high in the cycle where the count equals div
module uart_baud_gen (
    input  logic       i_Clock,
    input  logic       i_reset,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] div,
    output logic       tick
);
    logic [7:0] cnt;
    assign tick = en && cnt == div;
    always_ff @(posedge i_Clock or negedge i_reset)
        if (!i_reset) cnt <= '0;
        else          cnt <= (clr || tick) ? '0 : en ? cnt + 8'd1 : cnt;
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 transmit serializer, one start bit, LSB-first data, stop bit(s).
//   i_Clock - rising-edge clock
//   i_reset - asynchronous active-low reset
//   bus     - slave side of uart_tx_serializer_if (divisor, byte, start, line, busy, done)
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int STOP_BITS  = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_reset,
    uart_tx_serializer_if.slave  bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    tx_state_t                 state, state_d;
    logic [7:0]                brg_q;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [TW-1:0]             tcnt, tcnt_d;
    logic [BW-1:0]             bcnt, bcnt_d;
    logic                      tick, bit_end, accept, last_bit;
    logic                      tx_q, busy_q, done_q, tx_d, busy_d, done_d;
    assign bus.o_tx   = tx_q;
    assign bus.o_busy = busy_q;
    assign bus.o_done = done_q;
    assign accept   = state == IDLE && bus.i_start;
    assign bit_end  = tick && tcnt == TW'(OVERSAMPLE - 1);
    // bcnt counts data bits in DATA and stop bits in STOP
    assign last_bit = bcnt == BW'(state == DATA ? DATA_BITS - 1 : STOP_BITS - 1);
    // divisor is latched at start so a mid-frame i_brg change cannot alter this frame
    uart_baud_gen u_baud (
        .i_Clock (i_Clock),
        .i_reset (i_reset),
        .en      (busy_q),
        .clr     (accept),
        .div     (brg_q),
        .tick    (tick)
    );
    always_ff @(posedge i_Clock or negedge i_reset)
        if (!i_reset) state <= IDLE;
        else          state <= state_d;
    always_comb begin
        state_d = accept                       ? START :
                  !bit_end                     ? state :
                  state == START               ? DATA  :
                  !last_bit                    ? state :
                  state == DATA                ? STOP  :
                  state == STOP                ? IDLE  : state;
    end
    // outputs are computed from the next state and registered, so o_tx only moves at bit boundaries
    always_comb begin
        shift_d = accept ? bus.i_data : (state == DATA && bit_end) ? shift_q >> 1 : shift_q;
        tx_d    = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
        busy_d  = state_d != IDLE;
        done_d  = state != IDLE && state_d == IDLE;
        tcnt_d  = accept ? '0 : !tick ? tcnt : tcnt == TW'(OVERSAMPLE - 1) ? '0 : tcnt + TW'(1);
        bcnt_d  = accept ? '0 : !bit_end ? bcnt : (state == START || last_bit) ? '0 : bcnt + BW'(1);
    end
    always_ff @(posedge i_Clock or negedge i_reset)
        if (!i_reset) begin
            brg_q   <= '0;
            shift_q <= '0;
            tcnt    <= '0;
            bcnt    <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            brg_q   <= accept ? bus.i_brg : brg_q;
            shift_q <= shift_d;
            tcnt    <= tcnt_d;
            bcnt    <= bcnt_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: self-checking bench comparing the serial line against an 8N1 frame model.
module tb_uart_tx_serializer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    uart_tx_serializer_if bus ();
    uart_tx_serializer dut (.i_Clock(clk), .i_reset(rst_n), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic frame_bit(input logic [7:0] data, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return data[idx-1];
        return 1'b1;
    endfunction

    task automatic send(input logic [7:0] brg, input logic [7:0] data);
        bus.i_brg = brg;
        bus.i_data = data;
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
    endtask

    // checks every clock of a frame against the model; ends in the done cycle
    task automatic check_frame(input logic [7:0] brg, input logic [7:0] data, input bit disturb);
        int bp = 16 * (int'(brg) + 1);
        for (int b = 0; b < 10; b++) begin
            int bad = 0;
            logic exp = frame_bit(data, b);
            logic got_tx = exp;
            logic got_busy = 1'b1;
            for (int c = 0; c < bp; c++) begin
                if (disturb && b == 3 && c == 0) begin
                    bus.i_start = 1'b1;
                    bus.i_brg = 8'd7;
                    bus.i_data = ~data;
                end
                if (disturb && b == 3 && c == 1) bus.i_start = 1'b0;
                if (bus.o_tx !== exp || bus.o_busy !== 1'b1 || bus.o_done !== 1'b0) begin
                    bad++;
                    got_tx = bus.o_tx;
                    got_busy = bus.o_busy;
                end
                @(posedge clk); #1;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL frame_bit%0d brg=%0d data=%02h tx=%b busy=%b expected tx=%b busy=1 bad_cycles=%0d",
                         b, brg, data, got_tx, got_busy, exp, bad);
            end
        end
        checks++;
        if ({bus.o_done, bus.o_busy, bus.o_tx} !== 3'b101) begin
            failures++;
            $display("FAIL done_cycle done/busy/tx=%b%b%b expected 101", bus.o_done, bus.o_busy, bus.o_tx);
        end
    endtask

    task automatic frame(input logic [7:0] brg, input logic [7:0] data);
        send(brg, data);
        check_frame(brg, data, 1'b0);
        @(posedge clk); #1;
        checks++;
        if ({bus.o_done, bus.o_busy, bus.o_tx} !== 3'b001) begin
            failures++;
            $display("FAIL after_done done/busy/tx=%b%b%b expected 001", bus.o_done, bus.o_busy, bus.o_tx);
        end
    endtask

    task automatic test_reset();
        bus.i_start = 1'b0;
        bus.i_brg = 8'd0;
        bus.i_data = 8'd0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.o_done, bus.o_busy, bus.o_tx} !== 3'b001) begin
            failures++;
            $display("FAIL reset done/busy/tx=%b%b%b expected 001", bus.o_done, bus.o_busy, bus.o_tx);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        frame(8'd0, 8'h55);
    endtask

    task automatic test_slow();
        frame(8'd3, 8'hA5);
    endtask

    task automatic test_mid_frame_changes();
        int extra = 0;
        logic [7:0] d = 8'($urandom);
        send(8'd0, d);
        check_frame(8'd0, d, 1'b1);
        bus.i_brg = 8'd0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.o_busy !== 1'b0 || bus.o_tx !== 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL no_second_frame active_cycles=%0d expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d = 8'($urandom);
        send(8'd1, d);
        check_frame(8'd1, d, 1'b0);
        bus.i_data = 8'h00;
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        check_frame(8'd1, 8'h00, 1'b0);
        @(posedge clk); #1;
        checks++;
        if ({bus.o_done, bus.o_busy, bus.o_tx} !== 3'b001) begin
            failures++;
            $display("FAIL b2b_tail done/busy/tx=%b%b%b expected 001", bus.o_done, bus.o_busy, bus.o_tx);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) frame(8'($urandom_range(0, 2)), 8'($urandom));
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d = 8'($urandom) & 8'hEF;
        send(8'd0, d);
        repeat (85) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_done, bus.o_busy, bus.o_tx} !== 3'b001) begin
            failures++;
            $display("FAIL async_reset done/busy/tx=%b%b%b expected 001", bus.o_done, bus.o_busy, bus.o_tx);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({bus.o_done, bus.o_busy, bus.o_tx} !== 3'b001) begin
            failures++;
            $display("FAIL abandoned done/busy/tx=%b%b%b expected 001", bus.o_done, bus.o_busy, bus.o_tx);
        end
        frame(8'd0, 8'($urandom));
    endtask

    task automatic test_boundary();
        frame(8'd255, 8'hFF);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_slow();
        test_mid_frame_changes();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        test_boundary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
